// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops, and shifts that iterate
// one bit per clock in a dedicated SHIFT state.
module alu_multicycle (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [3:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        zero
);

  localparam int unsigned W   = 32;
  localparam int unsigned SHW = 5;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1011;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state;
  logic [W-1:0]     acc;
  logic [SHW-1:0]   cnt;
  logic [1:0]       sh_kind;

  logic [W-1:0]     alu_c;
  logic             is_shift_c;
  logic [SHW-1:0]   shamt_c;
  logic [W-1:0]     acc_next_c;

  // Single-cycle result; shift ops yield A, which is the shamt==0 answer.
  always_comb begin
    alu_c      = '0;
    is_shift_c = 1'b0;
    shamt_c    = b[SHW-1:0];
    case (alu_op)
      OP_ADD:  alu_c = a + b;
      OP_SUB:  alu_c = a - b;
      OP_SLT:  alu_c = W'($signed(a) < $signed(b));
      OP_SLTU: alu_c = W'(a < b);
      OP_AND:  alu_c = a & b;
      OP_OR:   alu_c = a | b;
      OP_XOR:  alu_c = a ^ b;
      OP_SLL, OP_SRL, OP_SRA: begin
        alu_c      = a;
        is_shift_c = 1'b1;
      end
      default: alu_c = '0;
    endcase
  end

  // One-bit step of the iterating shifter.
  always_comb begin
    acc_next_c = acc;
    case (sh_kind)
      SH_SLL:  acc_next_c = {acc[W-2:0], 1'b0};
      SH_SRL:  acc_next_c = {1'b0, acc[W-1:1]};
      default: acc_next_c = {acc[W-1], acc[W-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      sh_kind <= SH_SLL;
      result  <= '0;
      zero    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start && is_shift_c && (shamt_c != '0)) begin
            acc     <= a;
            cnt     <= shamt_c;
            sh_kind <= alu_op[1:0];
            state   <= SHIFT;
            busy    <= 1'b1;
            done    <= 1'b0;
          end else if (start) begin
            result  <= alu_c;
            zero    <= (alu_c == '0);
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
          end
        end
        SHIFT: begin
          // start is deliberately ignored here; result stays put until the last step.
          acc <= acc_next_c;
          cnt <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            result <= acc_next_c;
            zero   <= (acc_next_c == '0);
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
